// File: rtl/ps2_key_sequencer_if.sv
// Receiver-side and consumer-side signals of the PS/2 key sequencer.
// The sequencer uses the master modport; its environment uses the slave modport.
interface ps2_key_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    scan_code;
    logic          code_ready;
    logic          parity_error;
    logic          rx_clr;
    logic          key_valid;
    logic          key_ready;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_break;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    err_cnt;

    modport master (
        input  scan_code, code_ready, parity_error, key_ready, ovf_clr,
        output rx_clr, key_valid, key_code, key_ext, key_break,
               fifo_level, overflow, err_cnt
    );

    modport slave (
        output scan_code, code_ready, parity_error, key_ready, ovf_clr,
        input  rx_clr, key_valid, key_code, key_ext, key_break,
               fifo_level, overflow, err_cnt
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Decodes E0/F0/E1 PS/2 prefix sequences into key events, buffers them in a
// first-word-fall-through FIFO and supervises the receiver (errors, stalls).
module ps2_key_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                clk,
    input  logic                clr_n,
    ps2_key_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_code_ready_q, r_parity_error_q;
    logic            w_byte_stb, w_err_stb;
    logic [2:0]      r_skip, w_skip_nxt;
    logic [TW-1:0]   r_timer;
    logic            w_timeout;
    logic            w_push, w_push_ext, w_push_brk;
    logic [7:0]      w_push_code;
    logic            r_rx_clr;
    logic [7:0]      r_err_cnt;

    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [9:0]      r_hold;
    logic [9:0]      w_head;
    logic            w_valid, w_full, w_pop, w_wr, w_drop;
    logic            r_overflow;

    function automatic logic is_filtered(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_filtered = 1'b1;
            default:                                         is_filtered = 1'b0;
        endcase
    endfunction

    assign w_byte_stb = bus.code_ready & ~r_code_ready_q;
    assign w_err_stb  = bus.parity_error & ~r_parity_error_q;

    // Error beats byte, byte beats timeout: a byte landing on the last
    // allowed cycle still completes its sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_push      = 1'b0;
        w_push_code = bus.scan_code;
        w_push_ext  = 1'b0;
        w_push_brk  = 1'b0;
        w_timeout   = 1'b0;
        if (w_err_stb) begin
            w_state_nxt = S_IDLE;
        end else if (w_byte_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.scan_code == 8'hE0) begin
                        w_state_nxt = S_E0;
                    end else if (bus.scan_code == 8'hF0) begin
                        w_state_nxt = S_F0;
                    end else if (bus.scan_code == 8'hE1) begin
                        w_state_nxt = S_PAUSE;
                        w_skip_nxt  = 3'd7;
                    end else if (!is_filtered(bus.scan_code)) begin
                        w_push = 1'b1;
                    end
                end
                S_E0: begin
                    if (bus.scan_code == 8'hF0) begin
                        w_state_nxt = S_E0F0;
                    end else if (bus.scan_code != 8'hE0 && bus.scan_code != 8'hE1) begin
                        w_push      = 1'b1;
                        w_push_ext  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_F0: begin
                    w_push      = 1'b1;
                    w_push_brk  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_E0F0: begin
                    w_push      = 1'b1;
                    w_push_ext  = 1'b1;
                    w_push_brk  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_PAUSE: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_push      = 1'b1;
                        w_push_code = 8'hE1;
                        w_push_ext  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_timer == TMAX) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state          <= S_IDLE;
            r_skip           <= '0;
            r_timer          <= '0;
            r_code_ready_q   <= 1'b0;
            r_parity_error_q <= 1'b0;
            r_rx_clr         <= 1'b0;
            r_err_cnt        <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_skip           <= w_skip_nxt;
            r_code_ready_q   <= bus.code_ready;
            r_parity_error_q <= bus.parity_error;
            r_rx_clr         <= w_err_stb | w_timeout;
            if (w_byte_stb || w_err_stb || w_timeout || r_state == S_IDLE) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_err_stb && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = w_valid & bus.key_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_push_code, w_push_ext, w_push_brk};
        end
    end

    // While empty the head presents the last shown entry, not a stale slot.
    assign w_head = w_valid ? r_mem[r_rd_ptr] : r_hold;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_hold     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_hold <= w_head;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rx_clr     = r_rx_clr;
    assign bus.key_valid  = w_valid;
    assign bus.key_code   = w_head[9:2];
    assign bus.key_ext    = w_head[1];
    assign bus.key_break  = w_head[0];
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench: a byte-level decode model queues expected key events and a
// negedge monitor compares every accepted event against the queue head.
module tb_ps2_key_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_sequencer_if #(.DEPTH(DEPTH)) bus ();

    ps2_key_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  m_pause  = 0;
    bit  m_ext    = 1'b0;
    bit  m_brk    = 1'b0;
    int  m_err    = 0;
    bit  rdy_rand = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic bit filtered(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

    task automatic model_clear();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
    endtask

    // A completed event is stored unless the buffer is full with nothing leaving.
    task automatic model_emit(input logic [7:0] c, input bit e, input bit k);
        ev_t ev;
        model_clear();
        ev.code = c;
        ev.ext  = e;
        ev.brk  = k;
        if (exp_q.size() < DEPTH || bus.key_ready) exp_q.push_back(ev);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) model_emit(8'hE1, 1'b1, 1'b0);
        end else if (m_brk) begin
            model_emit(b, m_ext, 1'b1);
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hE1 && m_ext) begin
            m_ext = 1'b1;
        end else if (b == 8'hE1) begin
            m_pause = 7;
        end else if (!m_ext && filtered(b)) begin
            m_ext = 1'b0;
        end else begin
            model_emit(b, m_ext, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) bus.key_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        tick();
        bus.scan_code  = b;
        bus.code_ready = 1'b1;
        model_byte(b);
        repeat (hi) tick();
        bus.code_ready = 1'b0;
        repeat (lo - 1) tick();
    endtask

    task automatic pulse_parity();
        tick();
        bus.parity_error = 1'b1;
        tick();
        bus.parity_error = 1'b0;
        model_clear();
        m_err++;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (clr_n && bus.key_valid && bus.key_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got %0h/%0b/%0b expected none",
                         bus.key_code, bus.key_ext, bus.key_break);
            end else begin
                e = exp_q.pop_front();
                if ({bus.key_code, bus.key_ext, bus.key_break} != e) begin
                    failures++;
                    $display("FAIL event: got %0h/%0b/%0b expected %0h/%0b/%0b",
                             bus.key_code, bus.key_ext, bus.key_break, e.code, e.ext, e.brk);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_clr"},   bus.rx_clr,     0);
        chk({tag, "_valid"},    bus.key_valid,  0);
        chk({tag, "_code"},     bus.key_code,   0);
        chk({tag, "_ext"},      bus.key_ext,    0);
        chk({tag, "_break"},    bus.key_break,  0);
        chk({tag, "_level"},    bus.fifo_level, 0);
        chk({tag, "_overflow"}, bus.overflow,   0);
        chk({tag, "_err_cnt"},  bus.err_cnt,    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [7:0] b;
        bus.scan_code    = '0;
        bus.code_ready   = 1'b0;
        bus.parity_error = 1'b0;
        bus.key_ready    = 1'b1;
        bus.ovf_clr      = 1'b1;
        #12;
        chk_reset_outputs("reset");
        bus.ovf_clr = 1'b0;
        tick();
        clr_n = 1'b1;
        tick();

        // make / break with first-valid latency
        tick();
        bus.scan_code  = 8'h1C;
        bus.code_ready = 1'b1;
        model_byte(8'h1C);
        @(negedge clk);
        chk("valid_before_push", bus.key_valid, 0);
        tick();
        @(negedge clk);
        chk("valid_one_cycle_after", bus.key_valid, 1);
        repeat (2) tick();
        bus.code_ready = 1'b0;
        tick();
        send_byte(8'hF0, 2, 2);
        send_byte(8'h1C, 2, 2);
        repeat (3) tick();
        chk("makebreak_drained", exp_q.size(), 0);

        // extended codes, final byte held high for 50 cycles
        send_byte(8'hE0, 2, 2);
        send_byte(8'h75, 50, 3);
        send_byte(8'hE0, 2, 2);
        send_byte(8'hF0, 2, 2);
        send_byte(8'h75, 50, 3);
        repeat (3) tick();
        chk("extended_drained", exp_q.size(), 0);

        // pause sequence and filtered bytes
        send_byte(8'hE1, 2, 2);
        send_byte(8'h14, 2, 2);
        send_byte(8'h77, 2, 2);
        send_byte(8'hE1, 2, 2);
        send_byte(8'hF0, 2, 2);
        send_byte(8'h14, 2, 2);
        send_byte(8'hF0, 2, 2);
        send_byte(8'h77, 2, 2);
        repeat (3) tick();
        chk("pause_drained", exp_q.size(), 0);
        send_byte(8'hAA, 2, 2);
        send_byte(8'hFA, 2, 2);
        repeat (3) tick();
        @(negedge clk);
        chk("filter_level", bus.fifo_level, 0);

        // overflow: nine pushes into a stalled buffer
        bus.key_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1, 1);
        tick();
        @(negedge clk);
        chk("ovf_level", bus.fifo_level, DEPTH);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_head", bus.key_code, 8'h10);
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", bus.overflow, 0);
        bus.key_ready = 1'b1;
        repeat (10) tick();
        chk("ovf_drained", exp_q.size(), 0);

        // full buffer with a pop on the push cycle
        bus.key_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1, 1);
        tick();
        bus.key_ready  = 1'b1;
        bus.scan_code  = 8'h28;
        bus.code_ready = 1'b1;
        model_byte(8'h28);
        tick();
        bus.key_ready  = 1'b0;
        bus.code_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("fullpop_level", bus.fifo_level, DEPTH);
        chk("fullpop_overflow", bus.overflow, 0);
        chk("fullpop_head", bus.key_code, 8'h21);
        bus.key_ready = 1'b1;
        repeat (10) tick();
        chk("fullpop_drained", exp_q.size(), 0);

        // parity error after E0
        send_byte(8'hE0, 1, 1);
        tick();
        bus.parity_error = 1'b1;
        @(negedge clk);
        chk("err_rx_clr_same", bus.rx_clr, 0);
        tick();
        bus.parity_error = 1'b0;
        model_clear();
        m_err++;
        @(negedge clk);
        chk("err_rx_clr_pulse", bus.rx_clr, 1);
        tick();
        @(negedge clk);
        chk("err_rx_clr_after", bus.rx_clr, 0);
        chk("err_cnt_one", bus.err_cnt, 1);
        send_byte(8'h1C, 2, 2);
        repeat (3) tick();
        chk("err_recover_drained", exp_q.size(), 0);

        // stalled F0 times out after TIMEOUT cycles
        tick();
        bus.scan_code  = 8'hF0;
        bus.code_ready = 1'b1;
        model_byte(8'hF0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) bus.code_ready = 1'b0;
            if (k >= 16) begin
                @(negedge clk);
                chk($sformatf("timeout_rx_clr_%0d", k), bus.rx_clr, (k == 17) ? 1 : 0);
            end
        end
        model_clear();
        send_byte(8'h1C, 2, 2);
        repeat (3) tick();
        chk("timeout_recover_drained", exp_q.size(), 0);
        chk("timeout_err_cnt", bus.err_cnt, 1);

        // randomized traffic with random consumer stalls
        rdy_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!m_ext && !m_brk && m_pause == 0) begin
                waited = 0;
                while (exp_q.size() >= DEPTH && waited < 200) begin
                    tick();
                    waited++;
                end
                if (waited >= 200) chk("rand_flow_wait", exp_q.size(), DEPTH - 1);
            end
            if ($urandom_range(0, 29) == 0) pulse_parity();
            case ($urandom_range(0, 15))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = 8'hFA;
                6:       b = 8'hAA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, $urandom_range(1, 4), $urandom_range(1, 4));
        end
        rdy_rand      = 1'b0;
        bus.key_ready = 1'b1;
        model_clear();
        repeat (40) tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_err_cnt", bus.err_cnt, (m_err > 255) ? 255 : m_err);

        // async reset mid-sequence with events queued
        bus.key_ready = 1'b0;
        send_byte(8'h31, 1, 1);
        send_byte(8'h32, 1, 1);
        send_byte(8'h33, 1, 1);
        send_byte(8'hE0, 1, 1);
        tick();
        @(negedge clk);
        chk("prereset_level", bus.fifo_level, 3);
        #2;
        clr_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        exp_q.delete();
        model_clear();
        tick();
        clr_n = 1'b1;
        bus.key_ready = 1'b1;
        send_byte(8'h1C, 2, 2);
        repeat (3) tick();
        chk("postreset_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
